// File: rtl/cam_pattern_tx.sv
// Camera-style test-pattern source: emits FVAL/LVAL/D framing like a parallel
// CMOS sensor, with colour bars, ramp, fixed value or checkerboard content.
module cam_pattern_tx #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 160,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 4,
  parameter int unsigned V_BLANK  = 1000,
  parameter int unsigned BAR_W    = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [11:0] fixed_value,
  output logic [11:0] D,
  output logic        FVAL,
  output logic        LVAL,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  // x keeps at least 12 bits for the ramp, y at least 4 for the checkerboard
  localparam int unsigned X_W    = ($clog2(H_ACTIVE) > 12) ? $clog2(H_ACTIVE) : 12;
  localparam int unsigned Y_W    = ($clog2(V_ACTIVE) > 4) ? $clog2(V_ACTIVE) : 4;
  localparam int unsigned B_W    = ($clog2(BAR_W) > 1) ? $clog2(BAR_W) : 1;
  localparam int unsigned C_MAX0 = (V_FRONT > H_BLANK) ? V_FRONT : H_BLANK;
  localparam int unsigned C_MAX  = (C_MAX0 > V_BLANK) ? C_MAX0 : V_BLANK;
  localparam int unsigned C_W    = ($clog2(C_MAX) > 1) ? $clog2(C_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    VFRONT,
    LINE,
    HBLANK,
    VBLANK
  } state_t;

  state_t           state;
  logic [C_W-1:0]   cnt;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [2:0]       bar;
  logic [B_W-1:0]   bar_cnt;
  logic [1:0]       mode_q;
  logic [11:0]      fixed_q;

  logic [X_W-1:0]   nx;
  logic [Y_W-1:0]   ny;
  logic [2:0]       nbar;
  logic [B_W-1:0]   nbc;
  logic [11:0]      pix_c;

  // Coordinates and pixel value for the pixel that will be shown next cycle
  always_comb begin
    nx   = '0;
    ny   = y;
    nbar = 3'd0;
    nbc  = '0;
    if (state == LINE) begin
      nx = x + X_W'(1);
      if (bar_cnt == B_W'(BAR_W - 1)) begin
        nbc  = '0;
        nbar = (bar == 3'd7) ? 3'd7 : bar + 3'd1;
      end else begin
        nbc  = bar_cnt + B_W'(1);
        nbar = bar;
      end
    end else if (state == HBLANK) begin
      ny = y + Y_W'(1);
    end
    case (mode_q)
      2'd0:    pix_c = {nbar, 9'h000};
      2'd1:    pix_c = nx[11:0];
      2'd2:    pix_c = fixed_q;
      default: pix_c = (nx[3] ^ ny[3]) ? 12'hFFF : 12'h000;
    endcase
  end

  // Frame timing FSM; all outputs are loaded together with the state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      x           <= '0;
      y           <= '0;
      bar         <= 3'd0;
      bar_cnt     <= '0;
      mode_q      <= 2'd0;
      fixed_q     <= 12'h000;
      D           <= 12'h000;
      FVAL        <= 1'b0;
      LVAL        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 16'h0000;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state   <= VFRONT;
            FVAL    <= 1'b1;
            cnt     <= '0;
            y       <= '0;
            mode_q  <= mode;
            fixed_q <= fixed_value;
          end
        end
        VFRONT: begin
          if (cnt == C_W'(V_FRONT - 1)) begin
            state   <= LINE;
            LVAL    <= 1'b1;
            D       <= pix_c;
            x       <= nx;
            bar     <= nbar;
            bar_cnt <= nbc;
          end else begin
            cnt <= cnt + C_W'(1);
          end
        end
        LINE: begin
          if (x == X_W'(H_ACTIVE - 1)) begin
            LVAL <= 1'b0;
            D    <= 12'h000;
            cnt  <= '0;
            if (y == Y_W'(V_ACTIVE - 1)) begin
              state       <= VBLANK;
              FVAL        <= 1'b0;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end else begin
              state <= HBLANK;
            end
          end else begin
            x       <= nx;
            bar     <= nbar;
            bar_cnt <= nbc;
            D       <= pix_c;
          end
        end
        HBLANK: begin
          if (cnt == C_W'(H_BLANK - 1)) begin
            state   <= LINE;
            LVAL    <= 1'b1;
            D       <= pix_c;
            x       <= nx;
            y       <= ny;
            bar     <= nbar;
            bar_cnt <= nbc;
          end else begin
            cnt <= cnt + C_W'(1);
          end
        end
        VBLANK: begin
          if (cnt == C_W'(V_BLANK - 1)) begin
            cnt <= '0;
            y   <= '0;
            if (enable) begin
              state   <= VFRONT;
              FVAL    <= 1'b1;
              mode_q  <= mode;
              fixed_q <= fixed_value;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + C_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_pattern_tx.sv
// Directed bench for cam_pattern_tx using a small-frame parameter set.
module tb_cam_pattern_tx;

  localparam int H_ACTIVE = 8;
  localparam int H_BLANK  = 4;
  localparam int V_ACTIVE = 3;
  localparam int V_FRONT  = 2;
  localparam int V_BLANK  = 5;
  localparam int BAR_W    = 2;
  localparam int LINE_P   = H_ACTIVE + H_BLANK;
  localparam int FV_LEN   = V_FRONT + V_ACTIVE * H_ACTIVE + (V_ACTIVE - 1) * H_BLANK;
  localparam int PERIOD   = FV_LEN + V_BLANK;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [11:0] fixed_value;
  logic [11:0] D;
  logic        FVAL;
  logic        LVAL;
  logic        frame_done;
  logic [15:0] frame_count;

  int total = 0;
  int bad   = 0;
  int exp_fc = 0;

  cam_pattern_tx #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
    .V_FRONT(V_FRONT), .V_BLANK(V_BLANK), .BAR_W(BAR_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .fixed_value(fixed_value), .D(D), .FVAL(FVAL), .LVAL(LVAL),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int t, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_pix(input logic [1:0] m, input int px,
                                          input int py, input logic [11:0] fv);
    int b;
    b = px / BAR_W;
    if (b > 7) b = 7;
    case (m)
      2'd0:    return {3'(b), 9'h000};
      2'd1:    return 12'(px);
      2'd2:    return fv;
      default: return ((((px >> 3) ^ (py >> 3)) & 1) != 0) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  task automatic chk_quiet(input string tag, input int t);
    chk({tag, "_FVAL"}, t, 16'(FVAL), 16'h0);
    chk({tag, "_LVAL"}, t, 16'(LVAL), 16'h0);
    chk({tag, "_D"}, t, 16'(D), 16'h0);
    chk({tag, "_done"}, t, 16'(frame_done), 16'h0);
    chk({tag, "_count"}, t, frame_count, 16'(exp_fc));
  endtask

  // One full frame plus its vertical blank; called at the negedge where FVAL first reads 1
  task automatic run_frame(input logic [1:0] m, input logic [11:0] fv,
                           input int chg_t, input logic [1:0] nm,
                           input logic [11:0] nfv, input int off_t);
    int o;
    int ln;
    int p;
    logic ef;
    logic el;
    logic [11:0] ed;
    for (int t = 0; t < PERIOD; t++) begin
      o  = t - V_FRONT;
      ln = (o >= 0) ? o / LINE_P : 0;
      p  = (o >= 0) ? o % LINE_P : LINE_P;
      ef = (t < FV_LEN);
      el = (o >= 0) && ef && (p < H_ACTIVE);
      ed = el ? exp_pix(m, p, ln, fv) : 12'h000;
      chk("FVAL", t, 16'(FVAL), 16'(ef));
      chk("LVAL", t, 16'(LVAL), 16'(el));
      chk("D", t, 16'(D), 16'(ed));
      chk("frame_done", t, 16'(frame_done), 16'(t == FV_LEN));
      chk("frame_count", t, frame_count, 16'((t >= FV_LEN) ? exp_fc + 1 : exp_fc));
      if (t == chg_t) begin
        mode        = nm;
        fixed_value = nfv;
      end
      if (t == off_t) enable = 1'b0;
      @(negedge clk);
    end
    exp_fc = (exp_fc + 1) & 32'hFFFF;
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    mode        = 2'd0;
    fixed_value = 12'h000;
    repeat (2) @(negedge clk);
    chk_quiet("rst", 0);

    // Outputs must not move after release while enable stays low
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_quiet("idle", i);
    end

    mode   = 2'd1;
    enable = 1'b1;
    @(negedge clk);
    run_frame(2'd1, 12'h000, 36, 2'd0, 12'h000, -1);
    run_frame(2'd0, 12'h000, 36, 2'd2, 12'hABC, -1);
    run_frame(2'd2, 12'hABC, 5, 2'd1, 12'h555, -1);
    run_frame(2'd1, 12'h555, 5, 2'd3, 12'h000, -1);
    run_frame(2'd3, 12'h000, -1, 2'd3, 12'h000, V_FRONT + LINE_P + 2);
    for (int i = 0; i < 6; i++) begin
      chk_quiet("post_frame_idle", i);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of line 0, pixel 4
    mode   = 2'd1;
    enable = 1'b1;
    @(negedge clk);
    repeat (V_FRONT + 4) @(negedge clk);
    chk("mid_line_LVAL", 6, 16'(LVAL), 16'h1);
    chk("mid_line_D", 6, 16'(D), 16'h004);
    #1 reset = 1'b1;
    #1;
    exp_fc = 0;
    chk_quiet("async_rst", 6);
    @(negedge clk);
    reset = 1'b0;
    chk_quiet("rst_release", 0);
    @(negedge clk);
    run_frame(2'd1, 12'h000, -1, 2'd1, 12'h000, 20);
    chk_quiet("restart_idle", 0);

    // Wrap the frame counter from 0xFFFF
    force dut.frame_count = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count;
    @(negedge clk);
    exp_fc = 32'hFFFF;
    chk("preload_count", 0, frame_count, 16'hFFFF);
    mode        = 2'd2;
    fixed_value = 12'h0F0;
    enable      = 1'b1;
    @(negedge clk);
    run_frame(2'd2, 12'h0F0, -1, 2'd2, 12'h0F0, 10);
    for (int i = 0; i < 3; i++) begin
      chk_quiet("wrap_idle", i);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_pattern_tx.md
CAM_PATTERN_TX -- requirements
Module: cam_pattern_tx

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line (LVAL high clocks).
REQ-002 SHALL have parameter H_BLANK, default 160, meaning LVAL-low clocks between lines within a frame.
REQ-003 SHALL have parameter V_ACTIVE, default 480, meaning lines per frame.
REQ-004 SHALL have parameter V_FRONT, default 4, meaning clocks from FVAL rise to first LVAL rise.
REQ-005 SHALL have parameter V_BLANK, default 1000, meaning FVAL-low clocks between frames.
REQ-006 SHALL have parameter BAR_W, default 80, meaning colour-bar width in pixels.
REQ-007 SHALL have port clk, input, 1, meaning single clock; one pixel per clock (acts as camera PIXCLK).
REQ-008 SHALL have port reset, input, 1, meaning reset, asynchronous and active-high.
REQ-009 SHALL have port enable, input, 1, meaning run request.
REQ-010 SHALL have port mode, input, 2, meaning pattern select: 0 colour bars, 1 ramp, 2 fixed, 3 checkerboard.
REQ-011 SHALL have port fixed_value, input, 12, meaning pixel value for mode 2.
REQ-012 SHALL have port D, output, 12, meaning pixel data, matching terasic camera conduit D[11:0].
REQ-013 SHALL have port FVAL, output, 1, meaning frame valid.
REQ-014 SHALL have port LVAL, output, 1, meaning line valid.
REQ-015 SHALL have port frame_done, output, 1, meaning one-cycle end-of-frame pulse.
REQ-016 SHALL have port frame_count, output, 16, meaning completed-frame counter.

Function
REQ-017 SHALL drive D, FVAL, LVAL, frame_done and frame_count from registers only.
REQ-018 SHALL implement states IDLE, VFRONT, LINE, HBLANK, VBLANK.
REQ-019 IDLE SHALL hold FVAL=0 and LVAL=0; when enable=1 is sampled in IDLE, the FSM SHALL enter VFRONT, with FVAL=1 on the next cycle.
REQ-020 VFRONT SHALL last V_FRONT clocks with FVAL=1 and LVAL=0, then enter LINE.
REQ-021 LINE SHALL last H_ACTIVE clocks with FVAL=1 and LVAL=1, with pixel counter x running 0..H_ACTIVE-1 and line counter y fixed.
REQ-022 At the end of LINE, if y<V_ACTIVE-1, the FSM SHALL enter HBLANK, which lasts H_BLANK clocks with FVAL=1 and LVAL=0, then increments y and returns to LINE.
REQ-023 At the end of LINE, if y=V_ACTIVE-1, FVAL and LVAL SHALL fall on the same cycle and the FSM SHALL enter VBLANK.
REQ-024 VBLANK SHALL last V_BLANK clocks with FVAL=0, then enter VFRONT if enable=1, else IDLE.
REQ-025 frame_done SHALL be 1 for exactly the first VBLANK cycle, and frame_count SHALL increment on that same cycle, wrapping 0xFFFF->0x0000.
REQ-026 mode and fixed_value SHALL be latched on entry to VFRONT; changes during a frame SHALL take effect only in the next frame.
REQ-027 enable deasserted mid-frame SHALL NOT truncate the frame; the current frame and its VBLANK SHALL complete before IDLE.
REQ-028 D SHALL be 0 whenever LVAL=0.
REQ-029 In mode 0, D SHALL be {bar,9'h000}, where bar = (x/BAR_W) saturated at 7, computed with a bar counter (no divider).
REQ-030 In mode 1, D SHALL be x truncated to 12 bits.
REQ-031 In mode 2, D SHALL be the latched fixed_value.
REQ-032 In mode 3, D SHALL be 12'hFFF if x[3]^y[3], else 12'h000.
REQ-033 D for pixel x SHALL be presented in the same cycle that LVAL is high for pixel x (zero relative skew).

Reset
REQ-034 reset=1 SHALL immediately force state IDLE, FVAL=0, LVAL=0, D=0, frame_done=0, frame_count=0, x=0, y=0 and the latched mode to 0, including mid-line.
REQ-035 After reset release, no output SHALL change until enable=1 is sampled.

Verification (bench params H_ACTIVE=8, H_BLANK=4, V_ACTIVE=3, V_FRONT=2, V_BLANK=5, BAR_W=2)
REQ-036 Hold enable=1, mode=1 -> FVAL high for 34 clocks, then low for 5; period is 39 clocks; 3 LVAL pulses of 8 clocks separated by 4 clocks; D=0..7 on each line.
REQ-037 mode=0 -> D per line is 000,000,200,200,400,400,600,600; mode=2 with fixed_value=12'hABC -> D=ABC on all 24 pixels and 0 while LVAL=0.
REQ-038 Change mode from 1 to 3 mid-frame -> current frame remains a ramp; the next frame is a checkerboard (x[3]^y[3]=0 for all pixels at H_ACTIVE=8, so D=000).
REQ-039 Drop enable during line 1 -> frame completes, frame_done pulses once, frame_count=1, FSM returns to IDLE after 5 VBLANK clocks with FVAL=0.
REQ-040 Assert reset during LINE at x=4 -> FVAL, LVAL, D and frame_count are 0 in the same cycle; a subsequent enable restarts a full frame from VFRONT.
REQ-041 Preload frame_count to 0xFFFF via the force hook and complete one frame -> frame_count=0x0000 and frame_done is a single-cycle pulse.
